mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BUS, default 32, meaning data width.
REQ-002 SHALL have parameter AW, default 8, meaning word address width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, meaning CPU wait cycles before it overrides VGA priority.
REQ-004 SHALL have parameter KBD_ADDR, default 8'hFC, meaning fixed word address for keyboard writes.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- vga_req  in  1  VGA read request
- vga_addr  in  AW  VGA read address
- vga_gnt  out  1  VGA grant pulse
- vga_valid  out  1  VGA read data valid
- vga_rdata  out  BUS  VGA read data
- cpu_req  in  1  CPU request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  BUS  CPU write data
- cpu_gnt  out  1  CPU grant pulse
- cpu_valid  out  1  CPU read data valid
- cpu_rdata  out  BUS  CPU read data
- kbd_data  in  BUS  keyboard scan word, asynchronous to clk
- mem_addr  out  AW  memory address
- mem_wdata  out  BUS  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  BUS  memory read data, one cycle after mem_re

Function
REQ-006 SHALL sample requests at each rising edge and issue at most one memory command per cycle; back-to-back commands are allowed.
REQ-007 SHALL use FSM states IDLE, OWN_VGA, OWN_CPU, OWN_KBD. The next state SHALL be the arbitration winner, or IDLE if there is no request.
REQ-008 SHALL arbitrate with fixed priority VGA > CPU > KBD, except as REQ-009 states.
REQ-009 SHALL keep a CPU wait counter with these rules:
- increments each cycle cpu_req=1 without a grant
- saturates at MAX_WAIT
- while at MAX_WAIT, the CPU wins over VGA
- clears on cpu_gnt
REQ-010 SHALL register mem_addr, mem_wdata, mem_we, mem_re and the winner's gnt together, one cycle after the request is sampled.
REQ-011 SHALL assert the winner's gnt for exactly one cycle. A requester SHALL hold req, addr and data stable until gnt. A req still high after gnt is a new request.
REQ-012 SHALL pulse the owner's valid one cycle after a read command, with rdata = mem_rdata. Non-owner valid SHALL stay 0. rdata SHALL be 0 while valid=0.
REQ-013 SHALL never assert mem_we and mem_re in the same cycle. A CPU write SHALL produce no cpu_valid.
REQ-014 SHALL double-register kbd_data. When the synchronized value differs from the last value written, a pending flag SHALL be set.
REQ-015 SHALL serve a pending keyboard write as mem_we=1, mem_addr=KBD_ADDR, mem_wdata=latest synchronized value. The flag SHALL clear on grant unless the value changes in that same cycle.
REQ-016 SHALL hold mem_addr and mem_wdata at their last values, with mem_we=0 and mem_re=0, while in IDLE.

Reset
REQ-017 On reset low, all outputs SHALL go to 0 immediately. The FSM SHALL go to IDLE, the wait counter to 0, the keyboard pending flag to 0, and the last-written keyboard value to 0.
REQ-018 A reset asserted mid-read SHALL drop the pending valid. No stale valid SHALL appear after reset releases.

Configuration
REQ-019 SHALL use macro MEM_ARBITER_KBD_EN.
- Defined: the keyboard path per REQ-014/015 is present.
- Undefined: kbd_data is ignored, OWN_KBD is unreachable, and the synchronizer and pending logic are not built.

Structure
REQ-020 SHALL place the FSM state enum and the default KBD_ADDR constant in the shared package frogger_pkg.
REQ-021 SHALL implement the keyboard synchronizer and change detector as sub-module kbd_capture.

Verification
REQ-022 vga_req and cpu_req (read 0x10) rise together, MAX_WAIT=4 -> VGA is granted first; CPU is granted no later than 5 cycles later; cpu_valid returns mem_rdata from 0x10.
REQ-023 vga_req held high continuously, cpu_req rises -> after 4 VGA grants, cpu_gnt pulses; then VGA resumes.
REQ-024 CPU write 0x12=0xDEADBEEF -> one cycle with mem_we=1, mem_addr=0x12, mem_wdata=0xDEADBEEF; no cpu_valid.
REQ-025 kbd_data changes to 0x1C while idle -> within 4 cycles, one write 0x1C to 0xFC; no repeat while kbd_data is constant.
REQ-026 reset asserted on the cycle after a VGA read command -> outputs 0 immediately; vga_valid never pulses after release.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and constants for the mem_arbiter block.
//   arb_state_e      : arbiter FSM states; the state register also records the current bus owner
//   KBD_ADDR_DEFAULT : default word address that keyboard scan words are written to
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_VGA = 2'd1,
    OWN_CPU = 2'd2,
    OWN_KBD = 2'd3
  } arb_state_e;

  localparam logic [7:0] KBD_ADDR_DEFAULT = 8'hFC;

endpackage

// File: rtl/kbd_capture.sv
// Keyboard scan word synchronizer and change detector.
// Build option: MEM_ARBITER_KBD_EN. When it is undefined, no flops are built here, pending is
// tied to 0 and value to 0, so the arbiter never selects the keyboard.
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   kbd_data   : raw scan word, asynchronous to clk
//   grant      : the arbiter selects the keyboard write at this edge
//   pending    : a synchronized value not yet written to memory is waiting
//   value      : latest synchronized scan word
module kbd_capture #(
  parameter int unsigned BUS = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [BUS-1:0] kbd_data,
  input  logic           grant,
  output logic           pending,
  output logic [BUS-1:0] value
);

`ifdef MEM_ARBITER_KBD_EN
  logic [BUS-1:0] sync1_q, sync2_q;
  logic [BUS-1:0] last_q, last_d;
  logic           pending_q, pending_d;

  always_comb begin
    last_d    = last_q;
    pending_d = pending_q;
    if (grant) begin
      // sync2_q is the word being written now; stay pending if a newer word arrives this cycle
      last_d    = sync2_q;
      pending_d = (sync1_q != sync2_q);
    end else if (sync2_q != last_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      last_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= kbd_data;
      sync2_q   <= sync1_q;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign value   = sync2_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, reset, kbd_data, grant};
  assign pending       = 1'b0;
  assign value         = '0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for VGA reads, CPU reads/writes and keyboard scan-word writes.
// Fixed priority VGA > CPU > KBD, except that a CPU which has waited MAX_WAIT cycles beats VGA.
// At most one registered memory command per cycle; the winner's grant is registered with it.
// Build option: MEM_ARBITER_KBD_EN enables the keyboard path (see kbd_capture).
// Ports:
//   clk, reset                : clock, asynchronous active-low reset (all outputs to 0)
//   vga_req/addr              : VGA read request; vga_gnt grant pulse; vga_valid/rdata result
//   cpu_req/we/addr/wdata     : CPU request; cpu_gnt grant pulse; cpu_valid/rdata read result
//   kbd_data                  : keyboard scan word (asynchronous)
//   mem_addr/wdata/we/re      : memory command; mem_rdata returns one cycle after mem_re
module mem_arbiter
  import frogger_pkg::*;
#(
  parameter int unsigned    BUS      = 32,
  parameter int unsigned    AW       = 8,
  parameter int unsigned    MAX_WAIT = 4,
  parameter logic [AW-1:0]  KBD_ADDR = AW'(KBD_ADDR_DEFAULT)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           vga_req,
  input  logic [AW-1:0]  vga_addr,
  output logic           vga_gnt,
  output logic           vga_valid,
  output logic [BUS-1:0] vga_rdata,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [BUS-1:0] cpu_wdata,
  output logic           cpu_gnt,
  output logic           cpu_valid,
  output logic [BUS-1:0] cpu_rdata,
  input  logic [BUS-1:0] kbd_data,
  output logic [AW-1:0]  mem_addr,
  output logic [BUS-1:0] mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  input  logic [BUS-1:0] mem_rdata
);

  localparam int unsigned   WW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  arb_state_e     state_q, state_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [BUS-1:0] mem_wdata_q, mem_wdata_d;
  logic           mem_we_q, mem_we_d;
  logic           mem_re_q, mem_re_d;
  logic           vga_gnt_q, vga_gnt_d;
  logic           cpu_gnt_q, cpu_gnt_d;
  logic           vga_valid_q, vga_valid_d;
  logic           cpu_valid_q, cpu_valid_d;

  logic           kbd_pending;
  logic [BUS-1:0] kbd_value;
  logic           kbd_grant;

  kbd_capture #(
    .BUS (BUS)
  ) u_kbd_capture (
    .clk      (clk),
    .reset    (reset),
    .kbd_data (kbd_data),
    .grant    (kbd_grant),
    .pending  (kbd_pending),
    .value    (kbd_value)
  );

  always_comb begin
    state_d     = IDLE;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    vga_gnt_d   = 1'b0;
    cpu_gnt_d   = 1'b0;

    // Arbitration winner becomes the next owner
    if (cpu_req && (wait_q == WAIT_SAT)) begin
      state_d = OWN_CPU;
    end else if (vga_req) begin
      state_d = OWN_VGA;
    end else if (cpu_req) begin
      state_d = OWN_CPU;
    end else if (kbd_pending) begin
      state_d = OWN_KBD;
    end

    unique case (state_d)
      OWN_VGA: begin
        mem_addr_d = vga_addr;
        mem_re_d   = 1'b1;
        vga_gnt_d  = 1'b1;
      end
      OWN_CPU: begin
        mem_addr_d = cpu_addr;
        cpu_gnt_d  = 1'b1;
        if (cpu_we) begin
          mem_wdata_d = cpu_wdata;
          mem_we_d    = 1'b1;
        end else begin
          mem_re_d = 1'b1;
        end
      end
      OWN_KBD: begin
        mem_addr_d  = KBD_ADDR;
        mem_wdata_d = kbd_value;
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase

    if (state_d == OWN_CPU) begin
      wait_d = '0;
    end else if (cpu_req && (wait_q != WAIT_SAT)) begin
      wait_d = wait_q + 1'b1;
    end

    // state_q still names the owner of the read issued last cycle
    vga_valid_d = mem_re_q && (state_q == OWN_VGA);
    cpu_valid_d = mem_re_q && (state_q == OWN_CPU);
  end

  assign kbd_grant = (state_d == OWN_KBD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      vga_gnt_q   <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      vga_valid_q <= 1'b0;
      cpu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      vga_gnt_q   <= vga_gnt_d;
      cpu_gnt_q   <= cpu_gnt_d;
      vga_valid_q <= vga_valid_d;
      cpu_valid_q <= cpu_valid_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign vga_gnt   = vga_gnt_q;
  assign cpu_gnt   = cpu_gnt_q;
  assign vga_valid = vga_valid_q;
  assign cpu_valid = cpu_valid_q;
  // Read data is forced to zero outside the valid cycle
  assign vga_rdata = vga_valid_q ? mem_rdata : '0;
  assign cpu_rdata = cpu_valid_q ? mem_rdata : '0;

endmodule
